// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Program-counter stage. Holds the PC, picks the next PC from jump / branch
//   taken / sequential, and presents it to instruction memory over a
//   req/ready handshake. Handles boot, stall, halt and a sticky
//   misaligned-target trap.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   sel            branch taken from the selector (used in FETCH)
//   branch_offset  sign-extended byte offset, target = pc + offset
//   jump           unconditional jump request (overrides sel)
//   jump_target    absolute jump target
//   stall          hold PC this cycle, no fetch acceptance
//   halt           enter HALT (only reset leaves it)
//   imem_ready     instruction memory accepted the current PC
//   imem_req       PC valid for fetch
//   pc_out         current PC
//   pc_plus4       pc_out + 4, combinational link value
//   misalign_exc   sticky misaligned-taken-target flag
//   retired_cnt    accepted fetches
//   taken_cnt      taken branches and jumps
//
// Configuration macro
//   PC_PERF_CNT_EN  when defined, retired_cnt/taken_cnt are live counters;
//                   otherwise both outputs are tied to zero and no counter
//                   flops exist.
//
// state  | meaning
// -------+-----------------------------------------------------------
// BOOT   | first cycle after reset, imem_req low, then FETCH
// FETCH  | imem_req high, PC advances on imem_ready && !stall
// HALT   | imem_req low, PC frozen, exits only on reset
// TRAP   | imem_req low, PC frozen, misalign_exc high, reset only

module pc_next_unit #(
  parameter int                    PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [PC_WIDTH-1:0]  branch_offset,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_target,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 imem_ready,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic [PC_WIDTH-1:0]  pc_plus4,
  output logic                 misalign_exc,
  output logic [CNT_WIDTH-1:0] retired_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                req_q, req_d;
  logic                exc_q, exc_d;

  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] target;
  logic                taken;
  logic                accept;
  logic                advance;

  assign seq_pc = pc_q + PC_WIDTH'(4);
  assign taken  = jump | sel;

  always_comb begin
    target = seq_pc;
    if (jump) begin
      target = jump_target;
    end else if (sel) begin
      target = pc_q + branch_offset;
    end
  end

  // Halt beats acceptance; a misaligned taken target turns the accept into a trap.
  assign accept  = (state_q == ST_FETCH) && imem_ready && !stall && !halt;
  assign advance = accept && !(taken && (target[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (accept && !advance) begin
          state_d = ST_TRAP;
          exc_d   = 1'b1;
        end else if (advance) begin
          pc_d = target;
        end
      end
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
    req_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      req_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      exc_q   <= exc_d;
    end
  end

  assign imem_req     = req_q;
  assign pc_out       = pc_q;
  assign pc_plus4     = seq_pc;
  assign misalign_exc = exc_q;

`ifdef PC_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [CNT_WIDTH-1:0] taken_q, taken_d;

  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (advance) begin
      retired_d = retired_q + CNT_WIDTH'(1);
      if (taken) begin
        taken_d = taken_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;
`else
  assign retired_cnt = '0;
  assign taken_cnt   = '0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  localparam logic [63:0] RV = 64'h0;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [63:0] branch_offset;
  logic        jump;
  logic [63:0] jump_target;
  logic        stall;
  logic        halt;
  logic        imem_ready;
  logic        imem_req;
  logic [63:0] pc_out;
  logic [63:0] pc_plus4;
  logic        misalign_exc;
  logic [31:0] retired_cnt;
  logic [31:0] taken_cnt;

  pc_next_unit #(.PC_WIDTH(64), .RESET_VECTOR(RV), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .sel(sel), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .stall(stall), .halt(halt),
    .imem_ready(imem_ready), .imem_req(imem_req), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .misalign_exc(misalign_exc),
    .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: 0 boot, 1 fetch, 2 halt, 3 trap
  int          m_state;
  logic [63:0] m_pc;
  logic        m_exc;
  logic [31:0] m_ret;
  logic [31:0] m_tkn;

  typedef struct {
    logic [63:0] pc;
    logic        req;
    logic        exc;
    logic [31:0] ret;
    logic [31:0] tkn;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef PC_PERF_CNT_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = RV; m_exc = 1'b0; m_ret = '0; m_tkn = '0;
  endtask

  task automatic step(input logic i_sel, input logic [63:0] i_off, input logic i_jump,
                      input logic [63:0] i_jt, input logic i_stall, input logic i_halt,
                      input logic i_ready);
    logic [63:0] tgt;
    logic        tk;
    exp_t        e;
    exp_t        o;
    sel = i_sel; branch_offset = i_off; jump = i_jump; jump_target = i_jt;
    stall = i_stall; halt = i_halt; imem_ready = i_ready;
    tk  = i_jump | i_sel;
    tgt = i_jump ? i_jt : (i_sel ? m_pc + i_off : m_pc + 64'd4);
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (i_halt) m_state = 2;
      else if (i_ready && !i_stall) begin
        if (tk && tgt[1:0] != 2'b00) begin
          m_state = 3; m_exc = 1'b1;
        end else begin
          m_pc = tgt; m_ret++;
          if (tk) m_tkn++;
        end
      end
    end
    e.pc = m_pc; e.req = (m_state == 1); e.exc = m_exc;
    e.ret = cnt_exp(m_ret); e.tkn = cnt_exp(m_tkn);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk("pc", pc_out, o.pc);
    chk("req", {63'd0, imem_req}, {63'd0, o.req});
    chk("exc", {63'd0, misalign_exc}, {63'd0, o.exc});
    chk("pc4", pc_plus4, o.pc + 64'd4);
    chk("ret", {32'd0, retired_cnt}, {32'd0, o.ret});
    chk("tkn", {32'd0, taken_cnt}, {32'd0, o.tkn});
  endtask

  // Asserts reset between edges, checks the asynchronous effect, releases on a falling edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_reset();
    #1;
    chk({tag, "_pc"}, pc_out, RV);
    chk({tag, "_req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, "_exc"}, {63'd0, misalign_exc}, 64'd0);
    chk({tag, "_cnt"}, {32'd0, retired_cnt | taken_cnt}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    sel = 0; branch_offset = '0; jump = 0; jump_target = '0;
    stall = 0; halt = 0; imem_ready = 0; reset = 1'b1;
    model_reset();
    #3;
    do_reset("rst0");

    // Boot then sequential fetch
    idle(1'b1);
    chk("boot_pc", pc_out, 64'd0);
    chk("boot_req", {63'd0, imem_req}, 64'd1);
    idle(1'b1); chk("seq4", pc_out, 64'd4);
    idle(1'b1); chk("seq8", pc_out, 64'd8);
    idle(1'b1); chk("seq12", pc_out, 64'd12);

    // Branch and jump priority
    step(1'b0, 64'd0, 1'b1, 64'h100, 1'b0, 1'b0, 1'b1);
    chk("jmp100", pc_out, 64'h100);
    step(1'b1, -64'sd8, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("br_m8", pc_out, 64'hF8);
    step(1'b1, -64'sd8, 1'b1, 64'h400, 1'b0, 1'b0, 1'b1);
    chk("jmp_wins", pc_out, 64'h400);

    // Stall and not-ready hold the PC
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    chk("stall_hold", pc_out, 64'h400);
    for (int i = 0; i < 2; i++) idle(1'b0);
    chk("nrdy_hold", pc_out, 64'h400);

    // Random aligned traffic through the scoreboard
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), (64'($urandom_range(0, 255)) << 2) - 64'd512,
           1'($urandom_range(0, 3) == 0), {32'd0, $urandom} & ~64'h3,
           1'($urandom_range(0, 3) == 0), 1'b0, 1'($urandom_range(0, 3) != 0));
    end

    // Counters: boot + 10 advances, 3 of them taken
    do_reset("rst1");
    idle(1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 4 || i == 7) step(1'b1, 64'd16, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
      else idle(1'b1);
    end
    chk("ret10", {32'd0, retired_cnt}, {32'd0, cnt_exp(32'd10)});
    chk("tkn3", {32'd0, taken_cnt}, {32'd0, cnt_exp(32'd3)});

    // Wrap at the top of the address space, then halt, then async reset
    step(1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1);
    chk("pc_top", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("pc4_wrap", pc_plus4, 64'd0);
    idle(1'b1);
    chk("wrap0", pc_out, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'h800, 1'b0, 1'b1, 1'b1);
    chk("halt_req", {63'd0, imem_req}, 64'd0);
    chk("halt_pc", pc_out, 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 64'd4, 1'b1, 64'h800, 1'b0, 1'b0, 1'b1);
    chk("halt_frozen", pc_out, 64'd0);
    do_reset("rst_halt");
    idle(1'b1);
    idle(1'b1);
    chk("after_halt", pc_out, 64'd4);

    // Misaligned branch target traps
    step(1'b0, 64'd0, 1'b1, 64'h20, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'h6, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("trap_pc", pc_out, 64'h20);
    chk("trap_exc", {63'd0, misalign_exc}, 64'd1);
    chk("trap_req", {63'd0, imem_req}, 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("trap_stays", pc_out, 64'h20);

    // Misaligned jump target traps as well
    do_reset("rst2");
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 64'd0, 1'b1, 64'h402, 1'b0, 1'b0, 1'b1);
    chk("jtrap_pc", pc_out, 64'd4);
    chk("jtrap_exc", {63'd0, misalign_exc}, 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
